// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the byte-level UART register bridge.
// Also home to small helpers reused by future serial bridges.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_BUS_WR   = 3'd3,
    ST_BUS_RD   = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_SEND     = 3'd6
  } bridge_state_e;

  localparam logic [7:0] OP_WRITE     = 8'h57;
  localparam logic [7:0] OP_READ      = 8'h52;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h3F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'h01;
  endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Loadable down-counter with clear and enable; expired flags a count of zero.
// Clear has priority over load, load over decrement.
module bridge_timeout #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Counter register: clear, reload or count down towards zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/uart_reg_bridge.sv
// Command engine between the UART RX/TX FIFOs and an 8-bit register bus:
// 'W' addr data -> register write + ACK, 'R' addr -> register read + data byte.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rden,
  output logic [7:0] tx_data,
  output logic       tx_wren,
  input  logic       tx_full,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  bridge_state_e state_r;
  logic [7:0]    opcode_r;
  logic          pop_ok_s;
  logic          is_cmd_s;
  logic          tmo_clr_s;
  logic          tmo_load_s;
  logic          tmo_en_s;
  logic          tmo_expired_s;

  // rx_rden is registered, so the FIFO head is stale in the cycle the pop lands.
  assign pop_ok_s = !rx_empty && !rx_rden;
  assign is_cmd_s = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign busy     = (state_r != ST_IDLE);

  // Timeout control: reload on each pop into a byte-wait state, count while waiting.
  always_comb begin
    tmo_clr_s  = 1'b0;
    tmo_load_s = 1'b0;
    tmo_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_ok_s && is_cmd_s) begin
          tmo_load_s = 1'b1;
        end else begin
          tmo_clr_s = 1'b1;
        end
      end
      ST_GET_ADDR: begin
        if (pop_ok_s) begin
          tmo_load_s = 1'b1;
        end else begin
          tmo_en_s = 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (pop_ok_s) begin
          tmo_clr_s = 1'b1;
        end else begin
          tmo_en_s = 1'b1;
        end
      end
      default: begin
        tmo_clr_s = 1'b1;
      end
    endcase
  end

  bridge_timeout #(
    .WIDTH(24)
  ) u_timeout (
    .clk     (CLK),
    .rst     (rst),
    .clr     (tmo_clr_s),
    .load    (tmo_load_s),
    .load_val(TIMEOUT_CYCLES - 24'd1),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Protocol FSM with registered strobes, bus outputs and response byte.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      opcode_r  <= 8'h00;
      rx_rden   <= 1'b0;
      tx_wren   <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      tx_data   <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      err_count <= 8'h00;
    end else begin
      rx_rden <= 1'b0;
      tx_wren <= 1'b0;
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_ok_s) begin
            rx_rden  <= 1'b1;
            opcode_r <= rx_data;
            if (is_cmd_s) begin
              state_r <= ST_GET_ADDR;
            end else begin
              tx_data   <= NAK_BYTE;
              err_count <= sat_inc8(err_count);
              state_r   <= ST_SEND;
            end
          end
        end
        ST_GET_ADDR: begin
          if (pop_ok_s) begin
            rx_rden  <= 1'b1;
            reg_addr <= rx_data;
            state_r  <= (opcode_r == OP_WRITE) ? ST_GET_DATA : ST_BUS_RD;
          end else if (tmo_expired_s) begin
            err_count <= sat_inc8(err_count);
            state_r   <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (pop_ok_s) begin
            rx_rden   <= 1'b1;
            reg_wdata <= rx_data;
            state_r   <= ST_BUS_WR;
          end else if (tmo_expired_s) begin
            err_count <= sat_inc8(err_count);
            state_r   <= ST_IDLE;
          end
        end
        ST_BUS_WR: begin
          reg_we  <= 1'b1;
          tx_data <= ACK_BYTE;
          state_r <= ST_SEND;
        end
        ST_BUS_RD: begin
          reg_re  <= 1'b1;
          state_r <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          tx_data <= reg_rdata;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_full) begin
            tx_wren <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: FIFO and register-bus models run in one
// process; each scenario task checks its own hand-computed expectations.
module tb_uart_reg_bridge;

  logic       CLK;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rden;
  logic [7:0] tx_data;
  logic       tx_wren;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_rx = 0;
  int n_tx = 0;
  int n_we = 0;
  int n_re = 0;
  int viol = 0;
  int last_rx_cyc = 0;
  int last_tx_cyc = 0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;
  logic [7:0] re_addr = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];

  // Register file model: read data is the address XOR 1E (22 -> 3C, 05 -> 1B, 00 -> 1E).
  assign reg_rdata = reg_addr ^ 8'h1E;

  uart_reg_bridge #(.TIMEOUT_CYCLES(24'd16)) dut (
    .CLK(CLK), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rden(rx_rden),
    .tx_data(tx_data), .tx_wren(tx_wren), .tx_full(tx_full), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .err_count(err_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic refresh_rx();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  // One clock: sample strobes mid-cycle, then apply FIFO/bus effects just after the edge.
  task automatic step();
    logic rd, wr, we, re, emp, full;
    logic [7:0] td, ad, wd;
    @(negedge CLK);
    rd = rx_rden; wr = tx_wren; we = reg_we; re = reg_re;
    emp = rx_empty; full = tx_full; td = tx_data; ad = reg_addr; wd = reg_wdata;
    @(posedge CLK);
    #1;
    cyc++;
    if (rd) begin
      if (emp) viol++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      n_rx++;
      last_rx_cyc = cyc;
    end
    if (wr) begin
      if (full) viol++;
      tx_log.push_back(td);
      n_tx++;
      last_tx_cyc = cyc;
    end
    if (we) begin
      n_we++;
      we_addr = ad;
      we_data = wd;
    end
    if (re) begin
      n_re++;
      re_addr = ad;
    end
    refresh_rx();
  endtask

  task automatic wait_tx(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_tx < target && k < budget) begin
      step();
      k++;
    end
    ok = (n_tx >= target);
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_rx < target && k < budget) begin
      step();
      k++;
    end
    ok = (n_rx >= target);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if ({rx_rden, tx_wren, reg_we, reg_re, busy} !== 5'b00000) begin n_bad++; $display("FAIL reset_strobes: got %b expected 00000", {rx_rden, tx_wren, reg_we, reg_re, busy}); end
    n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_vec++; if (reg_addr !== 8'h00) begin n_bad++; $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); end
    n_vec++; if (reg_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); end
    n_vec++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL reset_err_count: got %h expected 00", err_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    int rx0 = n_rx, tx0 = n_tx, we0 = n_we, re0 = n_re;
    bit ok;
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hA5);
    wait_tx(tx0 + 1, 60, ok);
    step(); step();
    n_vec++; if (!ok) begin n_bad++; $display("FAIL write_done: got no push expected 1 push"); end
    n_vec++; if (n_we - we0 !== 1) begin n_bad++; $display("FAIL write_we_pulses: got %0d expected 1", n_we - we0); end
    n_vec++; if ({we_addr, we_data} !== 16'h10A5) begin n_bad++; $display("FAIL write_bus: got %h expected 10a5", {we_addr, we_data}); end
    n_vec++; if (n_tx - tx0 !== 1 || tx_log[tx_log.size()-1] !== 8'h4B) begin n_bad++; $display("FAIL write_resp: got %0d pushes last %h expected 1 push of 4b", n_tx - tx0, tx_log[tx_log.size()-1]); end
    n_vec++; if (n_rx - rx0 !== 3) begin n_bad++; $display("FAIL write_pops: got %0d expected 3", n_rx - rx0); end
    n_vec++; if (last_tx_cyc - last_rx_cyc !== 2) begin n_bad++; $display("FAIL write_latency: got %0d expected 2", last_tx_cyc - last_rx_cyc); end
    n_vec++; if (busy !== 1'b0 || n_re !== re0) begin n_bad++; $display("FAIL write_idle: got busy=%b reads=%0d expected busy=0 reads=0", busy, n_re - re0); end
  endtask

  task automatic test_read();
    int tx0 = n_tx, we0 = n_we, re0 = n_re;
    bit ok;
    push_rx(8'h52); push_rx(8'h22);
    wait_tx(tx0 + 1, 60, ok);
    step();
    n_vec++; if (!ok) begin n_bad++; $display("FAIL read_done: got no push expected 1 push"); end
    n_vec++; if (n_re - re0 !== 1 || re_addr !== 8'h22) begin n_bad++; $display("FAIL read_bus: got %0d reads addr %h expected 1 read addr 22", n_re - re0, re_addr); end
    n_vec++; if (tx_log[tx_log.size()-1] !== 8'h3C) begin n_bad++; $display("FAIL read_data: got %h expected 3c", tx_log[tx_log.size()-1]); end
    n_vec++; if (n_we !== we0) begin n_bad++; $display("FAIL read_no_we: got %0d writes expected 0", n_we - we0); end
    n_vec++; if (last_tx_cyc - last_rx_cyc !== 3) begin n_bad++; $display("FAIL read_latency: got %0d expected 3", last_tx_cyc - last_rx_cyc); end
  endtask

  task automatic test_unknown();
    int tx0 = n_tx;
    bit ok;
    push_rx(8'h41); push_rx(8'h52); push_rx(8'h05);
    wait_tx(tx0 + 2, 80, ok);
    step();
    n_vec++; if (!ok) begin n_bad++; $display("FAIL unknown_done: got %0d pushes expected 2", n_tx - tx0); end
    n_vec++; if (tx_log[tx0] !== 8'h3F) begin n_bad++; $display("FAIL unknown_nak: got %h expected 3f", tx_log[tx0]); end
    n_vec++; if (tx_log[tx_log.size()-1] !== 8'h1B) begin n_bad++; $display("FAIL unknown_next_read: got %h expected 1b", tx_log[tx_log.size()-1]); end
    n_vec++; if (err_count !== 8'h01) begin n_bad++; $display("FAIL unknown_err_count: got %h expected 01", err_count); end
  endtask

  task automatic test_backpressure();
    int tx0 = n_tx, we0 = n_we;
    bit ok;
    tx_full = 1'b1;
    push_rx(8'h57); push_rx(8'h30); push_rx(8'hC3);
    repeat (50) step();
    n_vec++; if (n_tx !== tx0) begin n_bad++; $display("FAIL bp_no_push: got %0d pushes expected 0", n_tx - tx0); end
    n_vec++; if (tx_data !== 8'h4B || busy !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got tx_data=%h busy=%b expected 4b 1", tx_data, busy); end
    n_vec++; if (n_we - we0 !== 1 || {we_addr, we_data} !== 16'h30C3) begin n_bad++; $display("FAIL bp_bus: got %0d writes %h expected 1 write 30c3", n_we - we0, {we_addr, we_data}); end
    tx_full = 1'b0;
    wait_tx(tx0 + 1, 10, ok);
    repeat (5) step();
    n_vec++; if (n_tx - tx0 !== 1 || tx_log[tx_log.size()-1] !== 8'h4B) begin n_bad++; $display("FAIL bp_release: got %0d pushes last %h expected 1 push of 4b", n_tx - tx0, tx_log[tx_log.size()-1]); end
  endtask

  task automatic test_timeout();
    int tx0, we0, n;
    bit ok;
    pulse_reset();
    tx0 = n_tx; we0 = n_we;
    push_rx(8'h57); push_rx(8'h07);
    wait_rx(n_rx + 2, 20, ok);
    // already one GET_DATA cycle in; 15 more make the 16 idle cycles
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    n_vec++; if (!ok || n !== 15) begin n_bad++; $display("FAIL timeout_cycles: got %0d expected 15 (ok=%b)", n, ok); end
    n_vec++; if (n_we !== we0 || n_tx !== tx0) begin n_bad++; $display("FAIL timeout_silent: got we=%0d tx=%0d expected 0 0", n_we - we0, n_tx - tx0); end
    n_vec++; if (err_count !== 8'h01) begin n_bad++; $display("FAIL timeout_err_count: got %h expected 01", err_count); end
    push_rx(8'h57); push_rx(8'h07); push_rx(8'h01);
    wait_tx(tx0 + 1, 60, ok);
    n_vec++; if (!ok || {we_addr, we_data} !== 16'h0701 || tx_log[tx_log.size()-1] !== 8'h4B) begin n_bad++; $display("FAIL timeout_recover: got bus %h resp %h expected 0701 4b", {we_addr, we_data}, tx_log[tx_log.size()-1]); end
  endtask

  task automatic test_timeout_edge();
    int tx0 = n_tx, we0 = n_we;
    bit ok;
    push_rx(8'h57); push_rx(8'h09);
    wait_rx(n_rx + 2, 20, ok);
    repeat (14) step();
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL edge_still_waiting: got busy=%b expected 1", busy); end
    push_rx(8'h6E);
    wait_tx(tx0 + 1, 30, ok);
    n_vec++; if (!ok || n_we - we0 !== 1 || {we_addr, we_data} !== 16'h096E) begin n_bad++; $display("FAIL edge_byte_wins: got %0d writes %h expected 1 write 096e", n_we - we0, {we_addr, we_data}); end
    n_vec++; if (err_count !== 8'h01 || tx_log[tx_log.size()-1] !== 8'h4B) begin n_bad++; $display("FAIL edge_no_error: got err=%h resp=%h expected 01 4b", err_count, tx_log[tx_log.size()-1]); end
  endtask

  task automatic test_reset_mid();
    int tx0 = n_tx;
    bit ok;
    push_rx(8'h57);
    wait_rx(n_rx + 1, 20, ok);
    repeat (3) step();
    rst = 1'b1;
    step();
    n_vec++; if ({rx_rden, tx_wren, reg_we, reg_re, busy} !== 5'b00000 || {tx_data, reg_addr, reg_wdata, err_count} !== 32'h0) begin n_bad++; $display("FAIL midrst_outputs: got %b %h expected 00000 00000000", {rx_rden, tx_wren, reg_we, reg_re, busy}, {tx_data, reg_addr, reg_wdata, err_count}); end
    rst = 1'b0;
    repeat (10) step();
    n_vec++; if (n_tx !== tx0) begin n_bad++; $display("FAIL midrst_no_resp: got %0d pushes expected 0", n_tx - tx0); end
    push_rx(8'h52); push_rx(8'h00);
    wait_tx(tx0 + 1, 60, ok);
    n_vec++; if (!ok || tx_log[tx_log.size()-1] !== 8'h1E || re_addr !== 8'h00) begin n_bad++; $display("FAIL midrst_read: got %h addr %h expected 1e 00", tx_log[tx_log.size()-1], re_addr); end
  endtask

  task automatic test_saturation();
    int tx0, not_nak;
    bit ok;
    pulse_reset();
    tx0 = n_tx;
    for (int i = 0; i < 300; i++) push_rx(8'h41);
    wait_tx(tx0 + 300, 1500, ok);
    step();
    not_nak = 0;
    for (int i = tx0; i < tx_log.size(); i++) if (tx_log[i] !== 8'h3F) not_nak++;
    n_vec++; if (!ok || not_nak !== 0) begin n_bad++; $display("FAIL sat_naks: got %0d pushes %0d non-nak expected 300 0", n_tx - tx0, not_nak); end
    n_vec++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL sat_err_count: got %h expected ff", err_count); end
  endtask

  task automatic test_strobe_rules();
    n_vec++; if (viol !== 0) begin n_bad++; $display("FAIL strobe_rules: got %0d violations expected 0", viol); end
  endtask

  initial begin
    rst = 1'b1;
    tx_full = 1'b0;
    refresh_rx();
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_saturation();
    test_strobe_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Byte-level command engine directly downstream of the uart block's RX FIFO and upstream of its TX FIFO.
- Pops command bytes, decodes a 2/3-byte read/write protocol, and drives a simple 8-bit register bus.
- Pushes one response byte per command back into the TX FIFO.
- Gives the host PC register access to on-board peripherals over the serial link.

Parameters:
- TIMEOUT_CYCLES, 24'd1200000, max idle cycles between bytes of one command before the partial command is discarded (100 ms at 12 MHz).
- ACK_BYTE, 8'h4B, response to a completed write ('K').
- NAK_BYTE, 8'h3F, response to an unknown opcode ('?').

Ports:
- CLK  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  head byte of the RX FIFO; valid whenever rx_empty=0 (first-word-fall-through).
- rx_empty  in  1  RX FIFO empty.
- rx_rden  out  1  one-cycle pop strobe to the RX FIFO.
- tx_data  out  8  byte to push into the TX FIFO.
- tx_wren  out  1  one-cycle push strobe to the TX FIFO.
- tx_full  in  1  TX FIFO full.
- reg_addr  out  8  register bus address.
- reg_wdata  out  8  register bus write data.
- reg_we  out  1  write strobe, one cycle.
- reg_re  out  1  read strobe, one cycle.
- reg_rdata  in  8  read data; sampled exactly one cycle after reg_re.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating count of NAKs plus timeouts.

Behaviour:
- Reset state (checked the cycle after any rst=1):
  - All strobes (rx_rden, tx_wren, reg_we, reg_re) are 0.
  - tx_data, reg_addr, reg_wdata and err_count are 0.
  - busy is 0; FSM is in IDLE; timeout counter is 0.
  - rst aborts any command mid-flight; no response is sent.
- Protocol:
  - Write is 'W'(0x57), addr, data; the response is ACK_BYTE.
  - Read is 'R'(0x52), addr; the response is the register data byte.
  - Any other first byte is popped; the response is NAK_BYTE and err_count increments.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND.
- IDLE:
  - When rx_empty=0: assert rx_rden for one cycle and latch the opcode.
  - 'W' or 'R' goes to GET_ADDR; any other byte loads NAK_BYTE into tx_data and goes to SEND.
- GET_ADDR:
  - On rx_empty=0: pop the byte and latch it into reg_addr.
  - For 'W' go to GET_DATA; for 'R' go to BUS_RD.
- GET_DATA: on rx_empty=0, pop the byte, latch it into reg_wdata, go to BUS_WR.
- BUS_WR: reg_we=1 for exactly one cycle; load ACK_BYTE into tx_data; go to SEND.
- BUS_RD: reg_re=1 for one cycle; go to RD_WAIT.
- RD_WAIT: capture reg_rdata into tx_data; go to SEND.
- SEND:
  - When tx_full=0: tx_wren=1 for one cycle, then return to IDLE.
  - While tx_full=1: hold tx_data, no strobe, wait indefinitely (no timeout in SEND).
- Strobe rules:
  - rx_rden is never asserted while rx_empty=1.
  - tx_wren is never asserted while tx_full=1.
  - At most one rx_rden per byte consumed; there are no back-to-back pops within one state.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA.
  - It clears on every popped byte and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1 with rx_empty still 1: go to IDLE, send no response, increment err_count.
  - If a byte arrives in the same cycle as the timeout, the byte wins (pop and continue).
- err_count saturates at 8'hFF and never wraps.
- Minimum latency with bytes already present and TX not full:
  - Write: last byte popped to tx_wren = 2 cycles.
  - Read: addr popped to tx_wren = 3 cycles.
- reg_addr and reg_wdata hold their last values between commands.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - the FSM state enum;
  - opcode constants OP_WRITE=8'h57 and OP_READ=8'h52;
  - default ACK/NAK bytes.
- One sub-module, bridge_timeout: a loadable down-counter with clear, enable and expired output. It stays reusable for a future SPI bridge.

Test Plan:
- Write, TX not full: preload RX with 57 10 A5 -> one reg_we pulse with reg_addr=10, reg_wdata=A5. tx_data=4B on a single tx_wren. busy ends low. Exactly 3 rx_rden pulses.
- Read: model reg_rdata=3C at addr 22, preload RX with 52 22 -> one reg_re pulse with reg_addr=22. The next tx_wren carries 3C. No reg_we.
- Unknown opcode 41 followed by 52 05 -> first response 3F and err_count=1. The following read completes normally.
- Backpressure: hold tx_full=1 for 50 cycles during a write -> no tx_wren and tx_data stays 4B. After release, exactly one push.
- Timeout, run with TIMEOUT_CYCLES=16: send 57 07 then nothing -> FSM returns to IDLE after 16 cycles, no reg_we, no TX byte, err_count=1. A subsequent complete 57 07 01 executes.
- Reset mid-command and saturation:
  - rst pulse after 57 only -> all outputs return to reset values, no response. Next 52 00 works.
  - 300 unknown bytes -> err_count=FF.
